// File: rtl/fpu_arb_pkg.sv
// Shared definitions for the FPU add/subtract arbiter: controller states and
// the rounding-mode encodings understood by the adder.
package fpu_arb_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        START = 3'd1,
        WAIT  = 3'd2,
        ACK   = 3'd3,
        RESP  = 3'd4
    } state_t;

    localparam logic [1:0] RM_NEAREST = 2'b00;
    localparam logic [1:0] RM_POS_INF = 2'b01;
    localparam logic [1:0] RM_NEG_INF = 2'b10;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: rotate valid by the pointer, take the
// lowest set bit, and map it back to an absolute requester index.
module rr_pick #(
    parameter int NREQ = 4,
    parameter int IDW  = 2
) (
    input  logic [NREQ-1:0] valid,
    input  logic [IDW-1:0]  ptr,
    output logic [NREQ-1:0] grant,
    output logic [IDW-1:0]  grant_idx,
    output logic            any_valid
);

    logic [IDW-1:0]  slot_idx [NREQ];
    logic [NREQ-1:0] rot_valid;

    // slot gi is the requester gi positions after the pointer, wrapped
    generate
        for (genvar gi = 0; gi < NREQ; gi++) begin : g_rot
            logic [IDW:0] sum;
            assign sum           = {1'b0, ptr} + (IDW+1)'(gi);
            assign slot_idx[gi]  = (sum >= (IDW+1)'(NREQ)) ? IDW'(sum - (IDW+1)'(NREQ))
                                                            : sum[IDW-1:0];
            assign rot_valid[gi] = valid[slot_idx[gi]];
        end
    endgenerate

    always_comb begin
        grant     = '0;
        grant_idx = '0;
        any_valid = |valid;
        for (int k = NREQ - 1; k >= 0; k--) begin
            if (rot_valid[k]) begin
                grant_idx = slot_idx[k];
            end
        end
        if (any_valid) begin
            grant[grant_idx] = 1'b1;
        end
    end

endmodule

// File: rtl/fpu_addsub_arbiter.sv
// Time-shares one FPU add/subtract unit between NREQ requesters: round-robin
// grant, beg/ack handshake with the adder, watchdog abort, held response.
module fpu_addsub_arbiter
    import fpu_arb_pkg::*;
#(
    parameter int W       = 32,
    parameter int NREQ    = 4,
    parameter int IDW     = 2,
    parameter int TIMEOUT = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NREQ-1:0]   req_valid,
    output logic [NREQ-1:0]   req_ready,
    input  logic [NREQ*W-1:0] req_data_x,
    input  logic [NREQ*W-1:0] req_data_y,
    input  logic [NREQ-1:0]   req_add_subt,
    input  logic [NREQ*2-1:0] req_r_mode,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [IDW-1:0]    resp_id,
    output logic [W-1:0]      resp_result,
    output logic              resp_ovf,
    output logic              resp_unf,
    output logic              resp_timeout,
    output logic              fpu_beg,
    output logic              fpu_ack,
    output logic [W-1:0]      fpu_data_x,
    output logic [W-1:0]      fpu_data_y,
    output logic              fpu_add_subt,
    output logic [1:0]        fpu_r_mode,
    input  logic              fpu_ready,
    input  logic [W-1:0]      fpu_result,
    input  logic              fpu_ovf,
    input  logic              fpu_unf
);

    localparam int             WDW      = $clog2(TIMEOUT);
    localparam logic [WDW-1:0] WD_LIMIT = WDW'(TIMEOUT - 1);

    state_t          state_reg, state_next;
    logic [IDW-1:0]  ptr_reg;
    logic [WDW-1:0]  wd_reg;
    logic [W-1:0]    x_reg, y_reg, result_reg;
    logic            add_subt_reg, ovf_reg, unf_reg, timeout_reg;
    logic [1:0]      r_mode_reg;
    logic [IDW-1:0]  owner_reg;

    logic [NREQ-1:0] pick_grant;
    logic [IDW-1:0]  pick_idx;
    logic            pick_any;

    logic [W-1:0]    slot_x  [NREQ];
    logic [W-1:0]    slot_y  [NREQ];
    logic [1:0]      slot_rm [NREQ];

    generate
        for (genvar gi = 0; gi < NREQ; gi++) begin : g_slot
            assign slot_x[gi]  = req_data_x[gi*W +: W];
            assign slot_y[gi]  = req_data_y[gi*W +: W];
            assign slot_rm[gi] = req_r_mode[gi*2 +: 2];
        end
    endgenerate

    rr_pick #(
        .NREQ (NREQ),
        .IDW  (IDW)
    ) u_pick (
        .valid     (req_valid),
        .ptr       (ptr_reg),
        .grant     (pick_grant),
        .grant_idx (pick_idx),
        .any_valid (pick_any)
    );

    always_comb begin
        state_next = state_reg;
        req_ready  = '0;
        fpu_beg    = 1'b0;
        fpu_ack    = 1'b0;
        resp_valid = 1'b0;
        case (state_reg)
            IDLE: begin
                // masked during reset so every output reads 0 while rst is held
                req_ready = rst ? '0 : pick_grant;
                if (pick_any) begin
                    state_next = START;
                end
            end
            START: begin
                fpu_beg    = 1'b1;
                state_next = WAIT;
            end
            WAIT: begin
                if (fpu_ready || (wd_reg == WD_LIMIT)) begin
                    state_next = ACK;
                end
            end
            ACK: begin
                fpu_ack    = 1'b1;
                state_next = RESP;
            end
            RESP: begin
                resp_valid = 1'b1;
                if (resp_ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg    <= IDLE;
            ptr_reg      <= '0;
            wd_reg       <= '0;
            x_reg        <= '0;
            y_reg        <= '0;
            add_subt_reg <= 1'b0;
            r_mode_reg   <= '0;
            owner_reg    <= '0;
            result_reg   <= '0;
            ovf_reg      <= 1'b0;
            unf_reg      <= 1'b0;
            timeout_reg  <= 1'b0;
        end else begin
            state_reg <= state_next;
            case (state_reg)
                IDLE: begin
                    if (pick_any) begin
                        x_reg        <= slot_x[pick_idx];
                        y_reg        <= slot_y[pick_idx];
                        add_subt_reg <= req_add_subt[pick_idx];
                        r_mode_reg   <= slot_rm[pick_idx];
                        owner_reg    <= pick_idx;
                        ptr_reg      <= (pick_idx == IDW'(NREQ - 1)) ? '0 : pick_idx + IDW'(1);
                    end
                end
                START: wd_reg <= '0;
                WAIT: begin
                    wd_reg <= wd_reg + WDW'(1);
                    // a ready in the limit cycle still delivers the real result
                    if (fpu_ready) begin
                        result_reg  <= fpu_result;
                        ovf_reg     <= fpu_ovf;
                        unf_reg     <= fpu_unf;
                        timeout_reg <= 1'b0;
                    end else if (wd_reg == WD_LIMIT) begin
                        result_reg  <= '0;
                        ovf_reg     <= 1'b0;
                        unf_reg     <= 1'b0;
                        timeout_reg <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign resp_id      = owner_reg;
    assign resp_result  = result_reg;
    assign resp_ovf     = ovf_reg;
    assign resp_unf     = unf_reg;
    assign resp_timeout = timeout_reg;
    assign fpu_data_x   = x_reg;
    assign fpu_data_y   = y_reg;
    assign fpu_add_subt = add_subt_reg;
    assign fpu_r_mode   = r_mode_reg;

endmodule

// File: tb/tb_fpu_addsub_arbiter.sv
// Directed + randomized bench for fpu_addsub_arbiter with a latency-programmable
// adder stub and a transaction-level round-robin reference model.
module tb_fpu_addsub_arbiter;
    import fpu_arb_pkg::*;

    localparam int W       = 32;
    localparam int NREQ    = 4;
    localparam int IDW     = 2;
    localparam int TIMEOUT = 64;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [NREQ-1:0]   req_valid = '0;
    logic [NREQ-1:0]   req_ready;
    logic [NREQ*W-1:0] req_data_x = '0;
    logic [NREQ*W-1:0] req_data_y = '0;
    logic [NREQ-1:0]   req_add_subt = '0;
    logic [NREQ*2-1:0] req_r_mode = '0;
    logic              resp_valid;
    logic              resp_ready = 1'b0;
    logic [IDW-1:0]    resp_id;
    logic [W-1:0]      resp_result;
    logic              resp_ovf, resp_unf, resp_timeout;
    logic              fpu_beg, fpu_ack;
    logic [W-1:0]      fpu_data_x, fpu_data_y;
    logic              fpu_add_subt;
    logic [1:0]        fpu_r_mode;
    logic              fpu_ready = 1'b0;
    logic [W-1:0]      fpu_result = '0;
    logic              fpu_ovf = 1'b0;
    logic              fpu_unf = 1'b0;

    int checks = 0;
    int errors = 0;

    fpu_addsub_arbiter #(
        .W(W), .NREQ(NREQ), .IDW(IDW), .TIMEOUT(TIMEOUT)
    ) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_data_x(req_data_x), .req_data_y(req_data_y),
        .req_add_subt(req_add_subt), .req_r_mode(req_r_mode),
        .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_id(resp_id), .resp_result(resp_result),
        .resp_ovf(resp_ovf), .resp_unf(resp_unf), .resp_timeout(resp_timeout),
        .fpu_beg(fpu_beg), .fpu_ack(fpu_ack),
        .fpu_data_x(fpu_data_x), .fpu_data_y(fpu_data_y),
        .fpu_add_subt(fpu_add_subt), .fpu_r_mode(fpu_r_mode),
        .fpu_ready(fpu_ready), .fpu_result(fpu_result),
        .fpu_ovf(fpu_ovf), .fpu_unf(fpu_unf)
    );

    always #5 clk = ~clk;

    // adder stub behaviour: {ovf, unf, result} for a given operation
    function automatic logic [W+1:0] stub_fn(input logic [W-1:0] x, input logic [W-1:0] y,
                                             input logic as, input logic [1:0] rm);
        if (x == 32'h3FC0_0000 && y == 32'h4010_0000 && !as) return {2'b00, 32'h4070_0000};
        if (x == 32'h7F00_0000 && y == 32'h7F00_0000 && !as) return {2'b10, 32'h7F80_0000};
        return {^x, ^y, (x ^ {y[15:0], y[31:16]}) + {29'd0, as, rm}};
    endfunction

    int   stub_lat  = 0;
    bit   stub_hang = 1'b0;
    int   stub_cnt  = 0;
    logic stub_busy = 1'b0;

    always @(posedge clk) begin
        if (rst) begin
            fpu_ready <= 1'b0;
            stub_busy <= 1'b0;
            stub_cnt  <= 0;
        end else begin
            if (fpu_beg) begin
                stub_busy <= 1'b1;
                stub_cnt  <= stub_lat;
            end else if (stub_busy && !fpu_ready && !stub_hang) begin
                if (stub_cnt == 0) begin
                    fpu_ready <= 1'b1;
                    {fpu_ovf, fpu_unf, fpu_result} <= stub_fn(fpu_data_x, fpu_data_y,
                                                              fpu_add_subt, fpu_r_mode);
                end else begin
                    stub_cnt <= stub_cnt - 1;
                end
            end
            if (fpu_ack) begin
                fpu_ready <= 1'b0;
                stub_busy <= 1'b0;
            end
        end
    end

    int cyc = 0, beg_cnt = 0, ack_cnt = 0, beg_cyc = 0, ack_cyc = 0, viol = 0;
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (!rst) begin
            if (fpu_beg) begin beg_cnt <= beg_cnt + 1; beg_cyc <= cyc; end
            if (fpu_ack) begin ack_cnt <= ack_cnt + 1; ack_cyc <= cyc; end
            if ((fpu_beg && fpu_ack) || ((fpu_beg || fpu_ack) && resp_valid && resp_ready))
                viol <= viol + 1;
        end
    end

    logic [W-1:0] op_x [NREQ];
    logic [W-1:0] op_y [NREQ];
    logic         op_as[NREQ];
    logic [1:0]   op_rm[NREQ];
    int           ptr_m = 0;
    int           hist [NREQ];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_op(input int i, input logic [W-1:0] x, input logic [W-1:0] y,
                          input logic as, input logic [1:0] rm);
        op_x[i] = x; op_y[i] = y; op_as[i] = as; op_rm[i] = rm;
        req_data_x[i*W +: W] = x;
        req_data_y[i*W +: W] = y;
        req_add_subt[i]      = as;
        req_r_mode[i*2 +: 2] = rm;
    endtask

    // Called during an IDLE cycle (after a clock edge); returns in the next IDLE cycle.
    task automatic run_txn(input logic [NREQ-1:0] mask, input int lat, input bit hang,
                           input int hold, output int gid);
        int exp_g = -1;
        int n, b0, a0, exp_gap;
        bit exp_to;
        logic [W+1:0] e;
        stub_lat  = lat;
        stub_hang = hang;
        req_valid = mask;
        #1;
        for (int i = 0; i < NREQ; i++)
            if (exp_g < 0 && mask[(ptr_m + i) % NREQ]) exp_g = (ptr_m + i) % NREQ;
        gid = exp_g;
        chk("req_ready_grant", 64'(req_ready), 64'(1 << exp_g));
        b0 = beg_cnt; a0 = ack_cnt;
        @(posedge clk); #1;
        ptr_m   = (exp_g + 1) % NREQ;
        exp_to  = hang || (lat >= TIMEOUT - 1);
        exp_gap = exp_to ? TIMEOUT + 1 : lat + 3;
        e       = exp_to ? '0 : stub_fn(op_x[exp_g], op_y[exp_g], op_as[exp_g], op_rm[exp_g]);
        chk("start_beg_ready", {62'd0, fpu_beg, |req_ready}, 64'b10);
        chk("fpu_operands", {fpu_data_x, fpu_data_y}, {op_x[exp_g], op_y[exp_g]});
        chk("fpu_mode", {61'd0, fpu_add_subt, fpu_r_mode}, {61'd0, op_as[exp_g], op_rm[exp_g]});
        n = 0;
        while (resp_valid !== 1'b1 && n < TIMEOUT + 20) begin
            @(posedge clk); #1;
            n++;
        end
        chk("resp_within_bound", 64'(n < TIMEOUT + 20), 64'd1);
        chk("resp_id", 64'(resp_id), 64'(exp_g));
        chk("resp_result", 64'(resp_result), 64'(e[W-1:0]));
        chk("resp_flags", {61'd0, resp_ovf, resp_unf, resp_timeout}, {61'd0, e[W+1], e[W], exp_to});
        chk("one_beg_one_ack", {32'(beg_cnt - b0), 32'(ack_cnt - a0)}, {32'd1, 32'd1});
        chk("beg_to_ack_cycles", 64'(ack_cyc - beg_cyc), 64'(exp_gap));
        for (int h = 0; h < hold; h++) begin
            @(posedge clk); #1;
            chk("resp_hold_stable",
                {21'd0, resp_valid, req_ready, fpu_beg, resp_id, resp_ovf, resp_unf, resp_timeout, resp_result},
                {21'd0, 1'b1, 4'b0, 1'b0, IDW'(exp_g), e[W+1], e[W], exp_to, e[W-1:0]});
        end
        resp_ready = 1'b1;
        @(posedge clk); #1;
        resp_ready = 1'b0;
        chk("resp_valid_drops", 64'(resp_valid), 64'd0);
        $display("txn id=%0d result=%h ovf=%0d unf=%0d timeout=%0d hold=%0d",
                 resp_id, resp_result, resp_ovf, resp_unf, resp_timeout, hold);
    endtask

    initial begin
        int g;
        for (int i = 0; i < NREQ; i++) set_op(i, 32'h0, 32'h0, 1'b0, RM_NEAREST);

        // reset state
        repeat (3) @(posedge clk);
        #1;
        chk("reset_ctrl", {55'd0, req_ready, resp_valid, fpu_beg, fpu_ack, resp_ovf, resp_unf},
            64'd0);
        chk("reset_data", {fpu_data_x, fpu_data_y}, 64'd0);
        chk("reset_resp", {27'd0, resp_id, resp_timeout, fpu_add_subt, fpu_r_mode, resp_result}, 64'd0);
        rst = 1'b0;

        // 1.5 + 2.25 on requester 0
        set_op(0, 32'h3FC0_0000, 32'h4010_0000, 1'b0, RM_NEAREST);
        run_txn(4'b0001, 2, 1'b0, 0, g);
        chk("t1_result_literal", 64'(resp_result), 64'h4070_0000);

        // overflow case on requester 2
        set_op(2, 32'h7F00_0000, 32'h7F00_0000, 1'b0, RM_POS_INF);
        run_txn(4'b0100, 1, 1'b0, 0, g);
        chk("t6_ovf_id", {61'd0, resp_ovf, resp_id}, {61'd0, 1'b1, 2'd2});

        // response back-pressure for 10 cycles, other requests pending
        set_op(3, $urandom, $urandom, 1'b1, RM_NEG_INF);
        run_txn(4'b1001, 3, 1'b0, 10, g);

        // watchdog abort, then normal service, then ready/limit tie and one-past
        set_op(1, $urandom, $urandom, 1'b0, RM_NEAREST);
        run_txn(4'b0010, 0, 1'b1, 0, g);
        set_op(2, $urandom, $urandom, 1'b1, RM_POS_INF);
        run_txn(4'b0110, 0, 1'b0, 0, g);
        run_txn(4'b1111, TIMEOUT - 2, 1'b0, 0, g);
        run_txn(4'b1111, TIMEOUT - 1, 1'b0, 1, g);
        req_valid = '0;

        // reset during WAIT
        @(posedge clk); #1;
        stub_hang = 1'b1;
        req_valid = 4'b0010;
        @(posedge clk); #1;
        req_valid = '0;
        repeat (5) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        chk("midrst_ctrl", {55'd0, req_ready, resp_valid, fpu_beg, fpu_ack, resp_ovf, resp_unf},
            64'd0);
        chk("midrst_data", {fpu_data_x, fpu_data_y}, 64'd0);
        chk("midrst_resp", {27'd0, resp_id, resp_timeout, fpu_add_subt, fpu_r_mode, resp_result}, 64'd0);
        rst = 1'b0;
        stub_hang = 1'b0;
        ptr_m = 0;
        for (int k = 0; k < 4; k++) begin
            @(posedge clk); #1;
            chk("no_stale_resp", {62'd0, resp_valid, fpu_beg}, 64'd0);
        end

        // all requesters held: grant order from pointer 0
        for (int i = 0; i < NREQ; i++) begin
            hist[i] = 0;
            set_op(i, $urandom, $urandom, 1'($urandom), 2'($urandom_range(0, 2)));
        end
        for (int k = 0; k < 2 * NREQ; k++) begin
            run_txn(4'b1111, $urandom_range(0, 4), 1'b0, 0, g);
            chk("rr_order", 64'(g), 64'(k % NREQ));
            hist[g]++;
        end
        for (int i = 0; i < NREQ; i++) chk("fairness_hist", 64'(hist[i]), 64'd2);

        // randomized traffic
        for (int k = 0; k < 16; k++) begin
            logic [NREQ-1:0] m;
            m = NREQ'($urandom_range(1, (1 << NREQ) - 1));
            for (int i = 0; i < NREQ; i++)
                set_op(i, $urandom, $urandom, 1'($urandom), 2'($urandom_range(0, 2)));
            run_txn(m, $urandom_range(0, 6), 1'b0, $urandom_range(0, 3), g);
        end
        req_valid = '0;
        @(posedge clk); #1;
        chk("handshake_exclusion", 64'(viol), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
